// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the negedge-registered 16-bit ALU: repeats one opcode,
// feeding each result back into the ALU's 16-bit input, then returns the result.
module alu_seq_ctrl #(
    parameter int CNT_W      = 4,
    parameter bit EARLY_STOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [2:0]       alu_opcode,
    output logic [7:0]       alu_in1,
    output logic [15:0]      alu_in2,
    input  logic [15:0]      alu_out,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic             rsp_flag,
    output logic [CNT_W-1:0] rsp_iters,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [2:0] OP_NONE   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_INC    = 3'b011;
    localparam logic [2:0] OP_RSHIFT = 3'b100;
    localparam logic [2:0] OP_LSHIFT = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       aluOpcode_q;
    logic [7:0]       aluIn1_q;
    logic [15:0]      aluIn2_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] iters_q;
    logic [15:0]      rspData_q;
    logic             rspFlag_q;
    logic [CNT_W-1:0] rspIters_q;
    logic             rspErr_q;

    logic [CNT_W-1:0] remaining_d;
    logic [CNT_W-1:0] iters_d;
    logic             legalOp;
    logic             earlyHit;
    logic             stopNow;

    assign legalOp     = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_INC) ||
                         (cmd_op == OP_RSHIFT) || (cmd_op == OP_LSHIFT);
    assign remaining_d = remaining_q - 1'b1;
    assign iters_d     = iters_q + 1'b1;
    // Only decrementing operations can legitimately reach zero and stay there.
    assign earlyHit    = EARLY_STOP && alu_flag &&
                         ((aluOpcode_q == OP_SUB) || (aluOpcode_q == OP_RSHIFT));
    assign stopNow     = (remaining_d == '0) || earlyHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aluOpcode_q <= OP_NONE;
            aluIn1_q    <= '0;
            aluIn2_q    <= '0;
            remaining_q <= '0;
            iters_q     <= '0;
            rspData_q   <= '0;
            rspFlag_q   <= 1'b0;
            rspIters_q  <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!legalOp || cmd_count == '0) begin
                            rspData_q  <= cmd_b;
                            rspFlag_q  <= 1'b0;
                            rspIters_q <= '0;
                            rspErr_q   <= !legalOp;
                            state_q    <= DONE;
                        end else begin
                            aluOpcode_q <= cmd_op;
                            aluIn1_q    <= cmd_a;
                            aluIn2_q    <= cmd_b;
                            remaining_q <= cmd_count;
                            iters_q     <= '0;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    iters_q     <= iters_d;
                    remaining_q <= remaining_d;
                    aluIn2_q    <= alu_out;
                    if (stopNow) begin
                        rspData_q   <= alu_out;
                        rspFlag_q   <= alu_flag;
                        rspIters_q  <= iters_d;
                        rspErr_q    <= 1'b0;
                        aluOpcode_q <= OP_NONE;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    aluOpcode_q <= OP_NONE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign alu_opcode = aluOpcode_q;
    assign alu_in1    = aluIn1_q;
    assign alu_in2    = aluIn2_q;
    assign rsp_data   = rspData_q;
    assign rsp_flag   = rspFlag_q;
    assign rsp_iters  = rspIters_q;
    assign rsp_err    = rspErr_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: two instances (early stop on/off), each
// driving its own behavioural negedge-registered ALU model.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_validB;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_count;
    logic        rsp_ready;
    logic        rsp_readyB;

    logic        cmd_ready,  cmd_readyB;
    logic [2:0]  alu_opcode, alu_opcodeB;
    logic [7:0]  alu_in1,    alu_in1B;
    logic [15:0] alu_in2,    alu_in2B;
    logic [15:0] alu_out,    alu_outB;
    logic        alu_flag,   alu_flagB;
    logic        rsp_valid,  rsp_validB;
    logic [15:0] rsp_data,   rsp_dataB;
    logic        rsp_flag,   rsp_flagB;
    logic [3:0]  rsp_iters,  rsp_itersB;
    logic        rsp_err,    rsp_errB;
    logic        busy,       busyB;

    int errors = 0;
    int checks = 0;
    int latency;
    logic [15:0] heldData;

    alu_seq_ctrl #(.CNT_W(4), .EARLY_STOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_iters(rsp_iters),
        .rsp_err(rsp_err), .busy(busy)
    );

    alu_seq_ctrl #(.CNT_W(4), .EARLY_STOP(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_validB), .cmd_ready(cmd_readyB),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
        .alu_opcode(alu_opcodeB), .alu_in1(alu_in1B), .alu_in2(alu_in2B),
        .alu_out(alu_outB), .alu_flag(alu_flagB),
        .rsp_valid(rsp_validB), .rsp_ready(rsp_readyB),
        .rsp_data(rsp_dataB), .rsp_flag(rsp_flagB), .rsp_iters(rsp_itersB),
        .rsp_err(rsp_errB), .busy(busyB)
    );

    // ALU reference behaviour: zero flag, except ADD which only clears it; 000 holds.
    function automatic logic [16:0] aluStep(input logic [2:0] op, input logic [7:0] in1,
                                            input logic [15:0] in2, input logic [15:0] prevOut,
                                            input logic prevFlag);
        logic [15:0] r;
        case (op)
            3'b001:  return {1'b0, in2 + {8'h00, in1}};
            3'b010:  begin r = in2 - {8'h00, in1}; return {(r == 16'h0), r}; end
            3'b011:  begin r = in2 + 16'h0001;     return {(r == 16'h0), r}; end
            3'b100:  begin r = in2 >> 1;           return {(r == 16'h0), r}; end
            3'b101:  begin r = in2 << 1;           return {(r == 16'h0), r}; end
            default: return {prevFlag, prevOut};
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        alu_out = '0; alu_flag = 1'b0;
        alu_outB = '0; alu_flagB = 1'b0;
    end

    always @(negedge clk) begin
        {alu_flag, alu_out}   <= aluStep(alu_opcode, alu_in1, alu_in2, alu_out, alu_flag);
        {alu_flagB, alu_outB} <= aluStep(alu_opcodeB, alu_in1B, alu_in2B, alu_outB, alu_flagB);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one command to the selected instance and returns the number of
    // posedges from acceptance (inclusive) until rsp_valid is seen.
    task automatic applyStimulus(input bit useB, input logic [2:0] op, input logic [7:0] a,
                                 input logic [15:0] b, input logic [3:0] cnt,
                                 output int lat);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_count = cnt;
        if (useB) cmd_validB = 1'b1; else cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_validB = 1'b0;
        lat = 1;
        while (!(useB ? rsp_validB : rsp_valid) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("rspValidSeen", 32'(useB ? rsp_validB : rsp_valid), 1);
    endtask

    task automatic consumeResponse(input bit useB);
        @(negedge clk);
        if (useB) rsp_readyB = 1'b1; else rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; rsp_readyB = 1'b0;
        checkOutput("rspValidDropped", 32'(useB ? rsp_validB : rsp_valid), 0);
        checkOutput("cmdReadyBack", 32'(useB ? cmd_readyB : cmd_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_validB = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_count = '0;
        rsp_ready = 1'b0; rsp_readyB = 1'b0;
        #1;
        checkOutput("rstCmdReady", 32'(cmd_ready), 1);
        checkOutput("rstOpcode", 32'(alu_opcode), 0);
        checkOutput("rstRspValid", 32'(rsp_valid), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply by repeated add: 10 + 4*3
        applyStimulus(1'b0, 3'b001, 8'd3, 16'd10, 4'd4, latency);
        checkOutput("addLatency", 32'(latency), 5);
        checkOutput("addData", 32'(rsp_data), 22);
        checkOutput("addIters", 32'(rsp_iters), 4);
        checkOutput("addErr", 32'(rsp_err), 0);
        checkOutput("addBusy", 32'(busy), 1);
        checkOutput("addOpcodeIdle", 32'(alu_opcode), 0);
        consumeResponse(1'b0);

        // Countdown 20 by 5 with early stop on zero
        applyStimulus(1'b0, 3'b010, 8'd5, 16'd20, 4'd8, latency);
        checkOutput("subEsLatency", 32'(latency), 5);
        checkOutput("subEsData", 32'(rsp_data), 0);
        checkOutput("subEsFlag", 32'(rsp_flag), 1);
        checkOutput("subEsIters", 32'(rsp_iters), 4);
        consumeResponse(1'b0);

        applyStimulus(1'b1, 3'b010, 8'd5, 16'd20, 4'd8, latency);
        checkOutput("subNoEsLatency", 32'(latency), 9);
        checkOutput("subNoEsData", 32'(rsp_dataB), 32'hFFEC);
        checkOutput("subNoEsFlag", 32'(rsp_flagB), 0);
        checkOutput("subNoEsIters", 32'(rsp_itersB), 8);
        consumeResponse(1'b1);

        applyStimulus(1'b0, 3'b101, 8'd0, 16'h0001, 4'd15, latency);
        checkOutput("lshData", 32'(rsp_data), 32'h8000);
        checkOutput("lshIters", 32'(rsp_iters), 15);
        checkOutput("lshLatency", 32'(latency), 16);
        consumeResponse(1'b0);

        applyStimulus(1'b0, 3'b100, 8'd0, 16'h0010, 4'd8, latency);
        checkOutput("rshData", 32'(rsp_data), 0);
        checkOutput("rshFlag", 32'(rsp_flag), 1);
        checkOutput("rshIters", 32'(rsp_iters), 5);
        consumeResponse(1'b0);

        // Zero count and illegal opcode bypass the ALU
        applyStimulus(1'b0, 3'b001, 8'd7, 16'h1234, 4'd0, latency);
        checkOutput("zeroLatency", 32'(latency), 1);
        checkOutput("zeroData", 32'(rsp_data), 32'h1234);
        checkOutput("zeroIters", 32'(rsp_iters), 0);
        checkOutput("zeroErr", 32'(rsp_err), 0);
        checkOutput("zeroFlag", 32'(rsp_flag), 0);
        checkOutput("zeroOpcode", 32'(alu_opcode), 0);
        consumeResponse(1'b0);

        applyStimulus(1'b0, 3'b111, 8'd7, 16'hBEEF, 4'd3, latency);
        checkOutput("illLatency", 32'(latency), 1);
        checkOutput("illErr", 32'(rsp_err), 1);
        checkOutput("illData", 32'(rsp_data), 32'hBEEF);
        checkOutput("illIters", 32'(rsp_iters), 0);
        checkOutput("illOpcode", 32'(alu_opcode), 0);
        consumeResponse(1'b0);

        // Increment wrap, then back-pressure the response
        applyStimulus(1'b0, 3'b011, 8'd0, 16'hFFFE, 4'd3, latency);
        checkOutput("incData", 32'(rsp_data), 32'h0001);
        checkOutput("incFlag", 32'(rsp_flag), 0);
        checkOutput("incIters", 32'(rsp_iters), 3);
        heldData = rsp_data;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("holdValid", 32'(rsp_valid), 1);
            checkOutput("holdData", 32'(rsp_data), 32'h0001);
            checkOutput("holdCmdReady", 32'(cmd_ready), 0);
        end
        consumeResponse(1'b0);

        // Asynchronous reset during the second iteration
        @(negedge clk);
        cmd_op = 3'b001; cmd_a = 8'd1; cmd_b = 16'd0; cmd_count = 4'd8; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #3;
        checkOutput("midIssueBusy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("arstCmdReady", 32'(cmd_ready), 1);
        checkOutput("arstOpcode", 32'(alu_opcode), 0);
        checkOutput("arstIn1", 32'(alu_in1), 0);
        checkOutput("arstIn2", 32'(alu_in2), 0);
        checkOutput("arstRspValid", 32'(rsp_valid), 0);
        checkOutput("arstRspData", 32'(rsp_data), 0);
        checkOutput("arstRspIters", 32'(rsp_iters), 0);
        checkOutput("arstBusy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 3'b001, 8'd1, 16'd0, 4'd2, latency);
        checkOutput("postRstData", 32'(rsp_data), 2);
        checkOutput("postRstIters", 32'(rsp_iters), 2);
        checkOutput("postRstLatency", 32'(latency), 3);
        consumeResponse(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command sequencer in front of the 16-bit ALU, which is negedge-registered with opcodes ADD=001, SUB=010, INC=011, R_SHIFT=100, L_SHIFT=101.
- Accepts one command: operation, 8-bit operand A, 16-bit operand B and an iteration count.
- Issues the operation to the ALU repeatedly, feeding each result back into the 16-bit ALU input.
- Returns the final result over a valid/ready response channel.
- Used for multiply-by-repeated-add, multi-bit shifts, bounded countdowns and repeated increments.

Parameters:
CNT_W, 4, width of iteration count and iteration counter.
EARLY_STOP, 1, when 1, SUB and R_SHIFT terminate as soon as the ALU reports flag=1 (zero result).

Ports:
clk  in  1  system clock; controller state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command (IDLE only).
cmd_op  in  3  ALU opcode to repeat.
cmd_a  in  8  operand A, constant across iterations.
cmd_b  in  16  initial operand B.
cmd_count  in  CNT_W  number of iterations requested.
alu_opcode  out  3  to ALU opcode; 000 whenever no operation is issued.
alu_in1  out  8  to ALU 8-bit input.
alu_in2  out  16  to ALU 16-bit input.
alu_out  in  16  ALU result; captured by the ALU on negedge.
alu_flag  in  1  ALU flag output.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  16  final accumulated result.
rsp_flag  out  1  ALU flag after the last iteration (0 if no iteration ran).
rsp_iters  out  CNT_W  iterations actually executed.
rsp_err  out  1  command opcode was illegal.
busy  out  1  high in ISSUE and DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - cmd_ready=1, alu_opcode=000, alu_in1=0, alu_in2=0.
  - rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_iters=0, rsp_err=0, busy=0.
  - Applies immediately, including mid-ISSUE or while a response is pending; the pending response is discarded.
- IDLE:
  - Command is accepted on a posedge with cmd_valid & cmd_ready.
  - Illegal op (000, 110, 111): go to DONE with rsp_data=cmd_b, rsp_err=1, rsp_iters=0, rsp_flag=0. No ALU operation is issued.
  - cmd_count=0: go to DONE with rsp_data=cmd_b, rsp_err=0, rsp_iters=0. No ALU operation is issued.
  - Otherwise: load alu_opcode=cmd_op, alu_in1=cmd_a, alu_in2=cmd_b, remaining=cmd_count, iters=0; go to ISSUE.
- ISSUE: one iteration per clk cycle.
  - ALU inputs are registered on posedge and stable through the following negedge, where the ALU samples them.
  - At the next posedge, sample alu_out/alu_flag, then set iters+1, remaining-1, alu_in2=alu_out.
  - Stop condition: remaining becomes 0, or (EARLY_STOP=1 and cmd_op is SUB or R_SHIFT and alu_flag=1).
  - On stop: rsp_data=alu_out, rsp_flag=alu_flag, rsp_iters=iters+1, alu_opcode=000, go to DONE.
- DONE:
  - rsp_valid=1 and the response fields are held stable until rsp_ready is sampled high on a posedge; then go to IDLE.
  - cmd_ready=0 throughout DONE, so there is no overlap of command and response.
- Latency: accept to rsp_valid = N+1 posedges for N executed iterations; 1 posedge for count=0 or illegal op.
- Arithmetic: 16-bit wrap, modulo 2^16, exactly as the ALU computes it. The controller does no arithmetic except counter decrements.
- ADD flag handling: the ALU's ADD flag only ever clears. The controller reports the flag as received and never uses it for ADD/INC/L_SHIFT termination.
- alu_in1 is constant for the whole command. The ALU always sees 000 outside ISSUE, so its outputs remain held.

Test Plan:
1. ADD a=3 b=10 count=4 -> rsp_data=22, rsp_iters=4, rsp_err=0, rsp_valid 5 posedges after accept.
2. SUB a=5 b=20 count=8, EARLY_STOP=1 -> stops at rsp_data=0, rsp_flag=1, rsp_iters=4. With EARLY_STOP=0 -> rsp_data=0xFFEC, rsp_iters=8.
3. L_SHIFT b=0x0001 count=15 -> rsp_data=0x8000. R_SHIFT b=0x0010 count=8 -> rsp_data=0, rsp_flag=1, rsp_iters=5.
4. count=0 with b=0x1234 -> rsp_data=0x1234, rsp_iters=0, one-cycle latency, alu_opcode stays 000. cmd_op=111 -> rsp_err=1, rsp_data=cmd_b.
5. INC b=0xFFFE count=3 -> rsp_data=0x0001 (wraps); hold rsp_ready=0 for 6 cycles -> response fields stable, cmd_ready=0 throughout.
6. Assert rst_n=0 mid-ISSUE, iteration 2 of 8 -> all outputs at reset values asynchronously; after release, a new ADD a=1 b=0 count=2 gives rsp_data=2.
